muldiv_sequencer: RTL

//  Multi-cycle sequencer for MULT/DIV, owning the HI/LO register pair and serving MFHI/MFLO.

---
 rtl/muldiv_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/DIV engine that owns the HI/LO pair and
// serves MFHI/MFLO. It runs a radix-2 shift-add multiplier or a restoring
// divider at one bit per cycle, and holds the pipeline through stall while busy.
// Optional feature macro: MULDIV_SIGNED_EN selects two's-complement MULT/DIV.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start             alu_ctrl/op_a/op_b valid this cycle
//   alu_ctrl[3:0]     1000 DIV, 1001 MULT, 1010 MFHI, 1011 MFLO
//   op_a, op_b        multiplicand/dividend, multiplier/divisor
//   stall             combinational, high whenever the FSM is not IDLE
//   done              one-cycle pulse; HI/LO hold the new result
//   div_zero          sticky flag for DIV by zero, cleared by the next MULT/DIV accept
//   hi, lo            HI/LO registers
//   mf_result         combinational MFHI/MFLO read port
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_MULT = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b1010;
  localparam logic [3:0] OP_MFLO = 4'b1011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;   // MUL: {partial hi, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd;  // multiplicand or divisor magnitude
  logic [CW-1:0]      cnt;
  logic               last;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_keep;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quot_res;
  logic [WIDTH-1:0]   rem_res;

`ifdef MULDIV_SIGNED_EN
  logic neg_res;   // product / quotient must be negated
  logic neg_rem;   // remainder takes the dividend's sign
  assign abs_a = op_a[WIDTH-1] ? (~op_a + WIDTH'(1)) : op_a;
  assign abs_b = op_b[WIDTH-1] ? (~op_b + WIDTH'(1)) : op_b;
`else
  assign abs_a = op_a;
  assign abs_b = op_b;
`endif

  assign stall = (state != IDLE);
  assign last  = (cnt == CW'(WIDTH - 1));

  // One iteration of each datapath, evaluated from the current working regs.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_keep  = ~div_diff[WIDTH];
    div_next  = {(div_keep ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc[WIDTH-2:0], div_keep};
  end

  // Final results as written into HI/LO on the edge into DONE.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    mul_res  = neg_res ? (~mul_next + (2*WIDTH)'(1)) : mul_next;
    quot_res = neg_res ? (~div_next[WIDTH-1:0] + WIDTH'(1)) : div_next[WIDTH-1:0];
    rem_res  = neg_rem ? (~div_next[2*WIDTH-1:WIDTH] + WIDTH'(1))
                       : div_next[2*WIDTH-1:WIDTH];
`else
    mul_res  = mul_next;
    quot_res = div_next[WIDTH-1:0];
    rem_res  = div_next[2*WIDTH-1:WIDTH];
`endif
  end

  // MFHI/MFLO read port.
  always_comb begin
    mf_result = '0;
    if (alu_ctrl == OP_MFHI)      mf_result = hi;
    else if (alu_ctrl == OP_MFLO) mf_result = lo;
  end

  // Sequencer FSM and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (alu_ctrl == OP_MULT || alu_ctrl == OP_DIV)) begin
            cnt      <= '0;
            div_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_res  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_rem  <= op_a[WIDTH-1];
`endif
            if (alu_ctrl == OP_MULT) begin
              state <= MUL;
              acc   <= {{WIDTH{1'b0}}, abs_b};
              opnd  <= abs_a;
            end else if (op_b == '0) begin
              // Divide by zero: fixed result, no iterations.
              state    <= DONE;
              done     <= 1'b1;
              hi       <= op_a;
              lo       <= '1;
              div_zero <= 1'b1;
            end else begin
              state <= DIV;
              acc   <= {{WIDTH{1'b0}}, abs_a};
              opnd  <= abs_b;
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
            hi    <= mul_res[2*WIDTH-1:WIDTH];
            lo    <= mul_res[WIDTH-1:0];
          end
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
            hi    <= rem_res;
            lo    <= quot_res;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
